// File: rtl/rgb_pkg.sv
// rtl/rgb_pkg.sv - shared RGB PWM constants, types and level mapping
package rgb_pkg;

    localparam int PERIOD_W = 4;
    localparam int LEVEL_W  = 3;

    typedef logic [LEVEL_W-1:0]  level_t;
    typedef logic [PERIOD_W:0]   hicnt_t;
    typedef logic [PERIOD_W-1:0] win_t;

    localparam hicnt_t LEVEL_MAX = hicnt_t'((1 << LEVEL_W) - 1);
    localparam win_t   WIN_LAST  = '1;

    // A count above the top colour level clamps to all ones.
    function automatic level_t count_to_level(hicnt_t c);
        return (c > LEVEL_MAX) ? '1 : c[LEVEL_W-1:0];
    endfunction

endpackage

// File: rtl/rgb_pwm_capture_if.sv
// rtl/rgb_pwm_capture_if.sv - PWM inputs and recovered-colour outputs of the capture block
interface rgb_pwm_capture_if;
    import rgb_pkg::*;

    logic   pwm_r;
    logic   pwm_g;
    logic   pwm_b;
    level_t color_r;
    level_t color_g;
    level_t color_b;
    logic   sat_r;
    logic   sat_g;
    logic   sat_b;
    logic   valid;
    logic   update;

    modport master (
        output pwm_r, pwm_g, pwm_b,
        input  color_r, color_g, color_b, sat_r, sat_g, sat_b, valid, update
    );

    modport slave (
        input  pwm_r, pwm_g, pwm_b,
        output color_r, color_g, color_b, sat_r, sat_g, sat_b, valid, update
    );

endinterface

// File: rtl/pwm_duty_meter.sv
// rtl/pwm_duty_meter.sv - per-line duty measurement with two-window stability filter
module pwm_duty_meter
    import rgb_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   pwm,
    input  logic   win_end,
    output level_t level,
    output logic   sat,
    output logic   accepted,
    output logic   changed
);

    logic   sync_1;
    logic   sync_2;
    hicnt_t hi;
    hicnt_t prev;
    hicnt_t cur;
    level_t next_level;
    logic   next_sat;

    // Running count including this cycle's sample; at window end it is the final window count.
    always_comb begin
        cur        = hi + hicnt_t'(sync_2);
        next_sat   = (cur > LEVEL_MAX);
        next_level = count_to_level(cur);
        accepted   = win_end && (cur == prev);
        changed    = accepted && ((next_level != level) || (next_sat != sat));
    end

    // Two-flop synchroniser for the possibly asynchronous PWM line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= pwm;
            sync_2 <= sync_1;
        end
    end

    // High counter restarts each window; the finished count becomes the reference for the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi   <= '0;
            prev <= '0;
        end else if (win_end) begin
            hi   <= '0;
            prev <= cur;
        end else begin
            hi   <= cur;
        end
    end

    // Outputs move only when two consecutive windows agree.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level <= '0;
            sat   <= 1'b0;
        end else if (accepted) begin
            level <= next_level;
            sat   <= next_sat;
        end
    end

endmodule

// File: rtl/rgb_pwm_capture.sv
// rtl/rgb_pwm_capture.sv - recovers R/G/B colour levels from three PWM lines
module rgb_pwm_capture
    import rgb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    rgb_pwm_capture_if.slave  bus
);

    win_t win;
    logic win_end;
    logic acc_r, acc_g, acc_b;
    logic chg_r, chg_g, chg_b;

    assign win_end = (win == WIN_LAST);

    // Free-running window counter shared by all three channels.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win <= '0;
        end else begin
            win <= win + win_t'(1);
        end
    end

    pwm_duty_meter u_meter_r (
        .clk      (clk),
        .rst      (rst),
        .pwm      (bus.pwm_r),
        .win_end  (win_end),
        .level    (bus.color_r),
        .sat      (bus.sat_r),
        .accepted (acc_r),
        .changed  (chg_r)
    );

    pwm_duty_meter u_meter_g (
        .clk      (clk),
        .rst      (rst),
        .pwm      (bus.pwm_g),
        .win_end  (win_end),
        .level    (bus.color_g),
        .sat      (bus.sat_g),
        .accepted (acc_g),
        .changed  (chg_g)
    );

    pwm_duty_meter u_meter_b (
        .clk      (clk),
        .rst      (rst),
        .pwm      (bus.pwm_b),
        .win_end  (win_end),
        .level    (bus.color_b),
        .sat      (bus.sat_b),
        .accepted (acc_b),
        .changed  (chg_b)
    );

    // valid latches on the first window all channels agree; update pulses alongside any output change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.valid  <= 1'b0;
            bus.update <= 1'b0;
        end else begin
            bus.update <= chg_r | chg_g | chg_b;
            if (acc_r && acc_g && acc_b) begin
                bus.valid <= 1'b1;
            end
        end
    end

endmodule
